zuma_config_sink: RTL and testbench

- Receiving end of the overlay configuration protocol (config_en / config_addr / config_data) driven by the configuration counter in the TB wrapper.
- Decodes each word into a stage one-hot write enable and a LUT row, checks that addresses arrive in strict sequence, and reports progress.
- Flags completion or a protocol error. Sits at the overlay's config port, ahead of the per-stage config storage.

---
 rtl/zuma_cfg_pkg.sv | 16 +
 rtl/zuma_config_sink_if.sv | 30 +++
 rtl/zuma_cfg_addr_decode.sv | 29 ++
 rtl/zuma_config_sink.sv | 135 +++++++++++++
 tb/tb_zuma_config_sink.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zuma_cfg_pkg.sv
// rtl/zuma_cfg_pkg.sv - shared state type and image sizing helper for the config sink
package zuma_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERROR
  } cfg_state_e;

  function automatic int unsigned total_words(input int unsigned lut_size,
                                               input int unsigned num_stages);
    return (32'd1 << lut_size) * num_stages;
  endfunction

endpackage

// File: rtl/zuma_config_sink_if.sv
// rtl/zuma_config_sink_if.sv - config word stream in, stage write strobes and status out
interface zuma_config_sink_if #(
  parameter int LUT_SIZE     = 6,
  parameter int NUM_STAGES   = 4,
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32
);

  logic                    config_en;
  logic [ADDR_WIDTH-1:0]   config_addr;
  logic [CONFIG_WIDTH-1:0] config_data;
  logic [NUM_STAGES-1:0]   wr_en;
  logic [LUT_SIZE-1:0]     wr_row;
  logic [CONFIG_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0]   progress;
  logic                    config_done;
  logic                    config_error;
  logic [ADDR_WIDTH-1:0]   error_addr;

  modport master (
    output config_en, config_addr, config_data,
    input  wr_en, wr_row, wr_data, progress, config_done, config_error, error_addr
  );

  modport slave (
    input  config_en, config_addr, config_data,
    output wr_en, wr_row, wr_data, progress, config_done, config_error, error_addr
  );

endinterface

// File: rtl/zuma_cfg_addr_decode.sv
// rtl/zuma_cfg_addr_decode.sv - splits a config address into range flag, stage one-hot and row
module zuma_cfg_addr_decode
  import zuma_cfg_pkg::*;
#(
  parameter int LUT_SIZE   = 6,
  parameter int NUM_STAGES = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range,
  output logic [NUM_STAGES-1:0] stage_oh,
  output logic [LUT_SIZE-1:0]   row
);

  localparam logic [ADDR_WIDTH-1:0] TOTAL_W = ADDR_WIDTH'(total_words(LUT_SIZE, NUM_STAGES));

  logic [ADDR_WIDTH-1:0] stage_idx;

  always_comb begin
    in_range  = addr < TOTAL_W;
    stage_idx = addr >> LUT_SIZE;
    row       = addr[LUT_SIZE-1:0];
    // Out-of-range addresses must never raise a strobe, even if their stage index aliases.
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_oh[i] = in_range && (stage_idx == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/zuma_config_sink.sv
// rtl/zuma_config_sink.sv - sequence-checking receiver for the overlay config stream
module zuma_config_sink
  import zuma_cfg_pkg::*;
#(
  parameter int LUT_SIZE     = 6,
  parameter int NUM_STAGES   = 4,
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  zuma_config_sink_if.slave cfg
);

  localparam logic [ADDR_WIDTH-1:0] TOTAL_W = ADDR_WIDTH'(total_words(LUT_SIZE, NUM_STAGES));
  localparam logic [ADDR_WIDTH-1:0] LAST_W  = TOTAL_W - 1'b1;

  cfg_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   expected_q, expected_d;
  logic [ADDR_WIDTH-1:0]   progress_q, progress_d;
  logic [NUM_STAGES-1:0]   wr_en_q, wr_en_d;
  logic [LUT_SIZE-1:0]     wr_row_q, wr_row_d;
  logic [CONFIG_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   error_addr_q, error_addr_d;

  logic                    in_range;
  logic [NUM_STAGES-1:0]   stage_oh;
  logic [LUT_SIZE-1:0]     row;
  logic                    addr_hit;
  logic                    addr_zero;
  logic                    take;
  logic [ADDR_WIDTH-1:0]   exp_cur;
  logic [ADDR_WIDTH-1:0]   prog_cur;

  zuma_cfg_addr_decode #(
    .LUT_SIZE  (LUT_SIZE),
    .NUM_STAGES(NUM_STAGES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .addr    (cfg.config_addr),
    .in_range(in_range),
    .stage_oh(stage_oh),
    .row     (row)
  );

  assign addr_hit  = in_range && (cfg.config_addr == expected_q);
  assign addr_zero = (cfg.config_addr == '0);

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    progress_d   = progress_q;
    wr_en_d      = '0;
    wr_row_d     = wr_row_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    error_d      = error_q;
    error_addr_d = error_addr_q;
    exp_cur      = expected_q;
    prog_cur     = progress_q;
    take         = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if (cfg.config_en && addr_hit) begin
          take = 1'b1;
        end else if (cfg.config_en || (state_q == LOAD)) begin
          // A gap while loading is a truncated image; report where it stopped.
          state_d      = ERROR;
          error_d      = 1'b1;
          error_addr_d = cfg.config_en ? cfg.config_addr : expected_q;
        end
      end
      DONE, ERROR: begin
        if (cfg.config_en && addr_zero) begin
          done_d   = 1'b0;
          error_d  = 1'b0;
          exp_cur  = '0;
          prog_cur = '0;
          take     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      wr_en_d    = stage_oh;
      wr_row_d   = row;
      wr_data_d  = cfg.config_data;
      expected_d = exp_cur + 1'b1;
      progress_d = (prog_cur >= TOTAL_W) ? TOTAL_W : prog_cur + 1'b1;
      if (exp_cur == LAST_W) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      expected_q   <= '0;
      progress_q   <= '0;
      wr_en_q      <= '0;
      wr_row_q     <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      progress_q   <= progress_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_addr_q <= error_addr_d;
    end
  end

  assign cfg.wr_en        = wr_en_q;
  assign cfg.wr_row       = wr_row_q;
  assign cfg.wr_data      = wr_data_q;
  assign cfg.progress     = progress_q;
  assign cfg.config_done  = done_q;
  assign cfg.config_error = error_q;
  assign cfg.error_addr   = error_addr_q;

endmodule

// File: tb/tb_zuma_config_sink.sv
// tb/tb_zuma_config_sink.sv - randomized and directed bench for the config sink
module tb_zuma_config_sink;

  localparam int LS    = 2;
  localparam int NS    = 3;
  localparam int CW    = 32;
  localparam int AW    = 32;
  localparam int ROWS  = 4;
  localparam int TOTAL = 12;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  zuma_config_sink_if #(.LUT_SIZE(LS), .NUM_STAGES(NS), .CONFIG_WIDTH(CW), .ADDR_WIDTH(AW)) cfg_if ();

  zuma_config_sink #(.LUT_SIZE(LS), .NUM_STAGES(NS), .CONFIG_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cfg    (cfg_if)
  );

  int errors = 0;
  int checks = 0;
  int strobes;

  // Stream-level view: how many words of the current image have landed and what went wrong.
  bit          m_active, m_done, m_err;
  int          m_count;
  logic [AW-1:0] m_erraddr;
  logic [NS-1:0] m_wr_en;
  logic [LS-1:0] m_row;
  logic [CW-1:0] m_data;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_count = 0;
    m_erraddr = '0; m_wr_en = '0; m_row = '0; m_data = '0;
  endtask

  task automatic model_word(input bit en, input logic [AW-1:0] addr, input logic [CW-1:0] data);
    bit restart;
    m_wr_en = '0;
    restart = en && (addr == 0) && (m_done || m_err || !m_active);
    if (restart) begin
      m_active = 1; m_done = 0; m_err = 0; m_count = 0;
    end else if (m_done || m_err || (!m_active && !en)) begin
      return;
    end else if (!en || addr != AW'(m_count)) begin
      m_err = 1;
      m_erraddr = en ? addr : AW'(m_count);
      return;
    end
    m_wr_en = NS'(1) << (int'(addr) / ROWS);
    m_row   = LS'(int'(addr) % ROWS);
    m_data  = data;
    m_count = m_count + 1;
    if (m_count == TOTAL) m_done = 1;
  endtask

  // Drive one word at a falling edge, let the rising edge take it, land on the next falling edge.
  task automatic drive(input bit en, input logic [AW-1:0] addr, input logic [CW-1:0] data);
    cfg_if.config_en   = en;
    cfg_if.config_addr = en ? addr : AW'($urandom);
    cfg_if.config_data = en ? data : CW'($urandom);
    model_word(en, addr, data);
    @(negedge clk);
    if (cfg_if.wr_en != '0) strobes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cfg_if.config_en = 1'b0; cfg_if.config_addr = '0; cfg_if.config_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cfg_if.wr_en, cfg_if.wr_row, cfg_if.wr_data, cfg_if.progress,
         cfg_if.config_done, cfg_if.config_error, cfg_if.error_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr_en=%b prog=%0d done=%b err=%b eaddr=%0d required all zero",
               cfg_if.wr_en, cfg_if.progress, cfg_if.config_done, cfg_if.config_error, cfg_if.error_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    strobes = 0;
    for (int a = 0; a < TOTAL + 2; a++) begin
      drive(1'b1, AW'(a), CW'(a * 3));
      checks++;
      if (cfg_if.wr_en !== m_wr_en) begin
        errors++;
        $display("FAIL full_wr_en addr=%0d got=%b required=%b", a, cfg_if.wr_en, m_wr_en);
      end
      if (a == 5) begin
        checks++;
        if (cfg_if.wr_en !== 3'b010 || cfg_if.wr_row !== 2'd1 || cfg_if.wr_data !== 32'd15) begin
          errors++;
          $display("FAIL full_addr5 got en=%b row=%0d data=%0d required en=010 row=1 data=15",
                   cfg_if.wr_en, cfg_if.wr_row, cfg_if.wr_data);
        end
      end
      if (a == TOTAL - 1) begin
        checks++;
        if (cfg_if.config_done !== 1'b1 || cfg_if.progress !== 32'd12 || cfg_if.wr_en !== 3'b100) begin
          errors++;
          $display("FAIL full_done got done=%b prog=%0d en=%b required done=1 prog=12 en=100",
                   cfg_if.config_done, cfg_if.progress, cfg_if.wr_en);
        end
      end
    end
    drive(1'b0, '0, '0);
    checks++;
    if (strobes != 12 || cfg_if.config_error !== 1'b0 || cfg_if.config_done !== 1'b1) begin
      errors++;
      $display("FAIL full_overrun got strobes=%0d err=%b done=%b required strobes=12 err=0 done=1",
               strobes, cfg_if.config_error, cfg_if.config_done);
    end
  endtask

  task automatic test_skip();
    logic [AW-1:0] seq [4] = '{0, 1, 2, 4};
    strobes = 0;
    foreach (seq[i]) drive(1'b1, seq[i], CW'($urandom));
    drive(1'b1, 5, 32'h55);
    drive(1'b1, 6, 32'h66);
    checks++;
    if (strobes != 3 || cfg_if.config_error !== 1'b1 || cfg_if.error_addr !== 32'd4 ||
        cfg_if.progress !== 32'd3) begin
      errors++;
      $display("FAIL skip got strobes=%0d err=%b eaddr=%0d prog=%0d required 3 1 4 3",
               strobes, cfg_if.config_error, cfg_if.error_addr, cfg_if.progress);
    end
  endtask

  task automatic test_truncation();
    for (int a = 0; a < 7; a++) drive(1'b1, AW'(a), CW'($urandom));
    checks++;
    if (cfg_if.config_error !== 1'b0 || cfg_if.progress !== 32'd7) begin
      errors++;
      $display("FAIL trunc_restart got err=%b prog=%0d required err=0 prog=7",
               cfg_if.config_error, cfg_if.progress);
    end
    drive(1'b0, '0, '0);
    checks++;
    if (cfg_if.config_error !== 1'b1 || cfg_if.error_addr !== 32'd7 || cfg_if.config_done !== 1'b0) begin
      errors++;
      $display("FAIL trunc got err=%b eaddr=%0d done=%b required err=1 eaddr=7 done=0",
               cfg_if.config_error, cfg_if.error_addr, cfg_if.config_done);
    end
  endtask

  task automatic test_duplicate();
    drive(1'b1, 0, 32'hA0);
    drive(1'b1, 1, 32'hA1);
    drive(1'b1, 1, 32'hA2);
    checks++;
    if (cfg_if.config_error !== 1'b1 || cfg_if.error_addr !== 32'd1 || cfg_if.wr_en !== 3'b000) begin
      errors++;
      $display("FAIL dup got err=%b eaddr=%0d en=%b required err=1 eaddr=1 en=000",
               cfg_if.config_error, cfg_if.error_addr, cfg_if.wr_en);
    end
  endtask

  task automatic test_restart();
    logic [CW-1:0] mem [TOTAL];
    logic [CW-1:0] got [TOTAL];
    int bad = 0;
    for (int a = 0; a < TOTAL; a++) begin
      mem[a] = CW'($urandom);
      drive(1'b1, AW'(a), mem[a]);
      if (cfg_if.wr_en != '0) got[int'(cfg_if.wr_en == 3'b001 ? 0 : cfg_if.wr_en == 3'b010 ? 1 : 2) * ROWS
                                  + int'(cfg_if.wr_row)] = cfg_if.wr_data;
      if (a == 0) begin
        checks++;
        if (cfg_if.config_error !== 1'b0 || cfg_if.config_done !== 1'b0 || cfg_if.progress !== 32'd1) begin
          errors++;
          $display("FAIL restart_clear got err=%b done=%b prog=%0d required 0 0 1",
                   cfg_if.config_error, cfg_if.config_done, cfg_if.progress);
        end
      end
    end
    for (int a = 0; a < TOTAL; a++) if (got[a] !== mem[a]) bad++;
    checks++;
    if (bad != 0 || cfg_if.config_done !== 1'b1 || cfg_if.progress !== 32'd12) begin
      errors++;
      $display("FAIL restart_load got bad_rows=%0d done=%b prog=%0d required 0 1 12",
               bad, cfg_if.config_done, cfg_if.progress);
    end
  endtask

  task automatic test_async_reset();
    for (int a = 0; a < 6; a++) drive(1'b1, AW'(a), CW'($urandom));
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cfg_if.wr_en, cfg_if.wr_row, cfg_if.wr_data, cfg_if.progress,
         cfg_if.config_done, cfg_if.config_error, cfg_if.error_addr} !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b prog=%0d done=%b err=%b required all zero",
               cfg_if.wr_en, cfg_if.progress, cfg_if.config_done, cfg_if.config_error);
    end
    model_reset();
    cfg_if.config_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    strobes = 0;
    for (int a = 0; a < TOTAL; a++) drive(1'b1, AW'(a), CW'($urandom));
    checks++;
    if (strobes != 12 || cfg_if.config_done !== 1'b1 || cfg_if.config_error !== 1'b0 ||
        cfg_if.progress !== 32'd12) begin
      errors++;
      $display("FAIL async_reload got strobes=%0d done=%b err=%b prog=%0d required 12 1 0 12",
               strobes, cfg_if.config_done, cfg_if.config_error, cfg_if.progress);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      int r = int'($urandom_range(0, 99));
      bit en = 1'b1;
      logic [AW-1:0] addr;
      if (r < 4)       en = 1'b0;
      else if (r < 9)  addr = AW'($urandom_range(0, 15));
      else if (r < 11) addr = '0;
      else if (m_done || m_err) addr = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'(TOTAL + $urandom_range(0, 1));
      else addr = AW'(m_count);
      drive(en, addr, CW'($urandom));
      checks++;
      if (cfg_if.wr_en !== m_wr_en || cfg_if.wr_data !== m_data ||
          (m_wr_en != '0 && cfg_if.wr_row !== m_row)) begin
        errors++;
        $display("FAIL rand_write step=%0d got en=%b row=%0d data=%h required en=%b row=%0d data=%h",
                 s, cfg_if.wr_en, cfg_if.wr_row, cfg_if.wr_data, m_wr_en, m_row, m_data);
      end
      checks++;
      if (cfg_if.progress !== AW'(m_count) || cfg_if.config_done !== m_done ||
          cfg_if.config_error !== m_err || cfg_if.error_addr !== m_erraddr) begin
        errors++;
        $display("FAIL rand_status step=%0d got prog=%0d done=%b err=%b eaddr=%0d required %0d %b %b %0d",
                 s, cfg_if.progress, cfg_if.config_done, cfg_if.config_error, cfg_if.error_addr,
                 m_count, m_done, m_err, m_erraddr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_skip();
    test_truncation();
    test_duplicate();
    test_restart();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
